// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The optional subtract port and the overflow flag exist only with SERIAL_ADDER_SUB_EN.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
    logic             ovf;

    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_cell.sv
// Combinational 1-bit full adder; the only arithmetic in the serial adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (b & cin) | (a & cin);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands stream LSB-first through one full-adder cell.
// Optional macro SERIAL_ADDER_SUB_EN adds a subtract mode and a signed-overflow flag.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q;
    logic [CW-1:0]    cnt;
    logic             cell_sum, cell_carry, last_bit, load_sub;
`ifdef SERIAL_ADDER_SUB_EN
    logic             ovf_q;

    assign load_sub = bus.sub;
    assign bus.ovf  = ovf_q;
`else
    assign load_sub = 1'b0;
`endif

    full_adder_cell u_cell (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .cin   (carry_q),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtract is a + ~b + 1: invert B on load and seed the carry with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt     <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= load_sub ? ~bus.b : bus.b;
                        carry_q <= load_sub | bus.cin;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    sum_q   <= {cell_sum, sum_q[WIDTH-1:1]};
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= cell_carry;
                    cnt     <= cnt + CW'(1);
                    if (last_bit) begin
                        cout_q <= cell_carry;
`ifdef SERIAL_ADDER_SUB_EN
                        ovf_q  <= carry_q ^ cell_carry;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance for directed/random work
// and a 4-bit instance for the exhaustive sweep, both checked against plain arithmetic.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(4)) bus4 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    // Reference: returns {ovf, cout, sum[7:0]} from integer arithmetic.
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic sub);
        int unsigned ua = a, ub = b, t;
        int          sa = int'($signed(a)), sb = int'($signed(b)), sr;
        logic        co, ov;
        if (sub) begin
            t  = (ua - ub) & 32'hFF;
            co = (ua >= ub);
            sr = sa - sb;
        end else begin
            t  = ua + ub + cin;
            co = t[8];
            sr = sa + sb + int'(cin);
        end
        ov = (sr > 127) || (sr < -128);
        return {ov, co, t[7:0]};
    endfunction

    task automatic set_sub8(input logic v);
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub = v;
`endif
    endtask

    function automatic logic get_ovf8();
`ifdef SERIAL_ADDER_SUB_EN
        return bus8.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // One handshake on the 8-bit instance; lat counts edges from accept to out_valid.
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input logic isub, input int stall,
                        output logic [7:0] s, output logic co, output logic ov,
                        output int lat);
        int n = 0;
        @(negedge clk);
        bus8.a = ia; bus8.b = ib; bus8.cin = ic; set_sub8(isub);
        bus8.in_valid  = 1'b1;
        bus8.out_ready = (stall == 0);
        while (!bus8.in_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
        set_sub8(1'($urandom));
        lat = 0;
        while (!bus8.out_valid && lat < 50) begin @(negedge clk); lat++; end
        if (n >= 50) lat = 99;
        s = bus8.sum; co = bus8.cout; ov = get_ovf8();
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            bus8.out_ready = 1'b1;
        end
    endtask

    task automatic test_reset;
        bus8.in_valid = 0; bus8.out_ready = 0; bus8.a = 0; bus8.b = 0; bus8.cin = 0;
        bus4.in_valid = 0; bus4.out_ready = 0; bus4.a = 0; bus4.b = 0; bus4.cin = 0;
        set_sub8(1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        bus4.sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus8.in_ready); end
        total++; if (bus8.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus8.out_valid); end
        total++; if (bus8.sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h exp=00", bus8.sum); end
        total++; if (bus8.cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", bus8.cout); end
        total++; if (get_ovf8() !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", get_ovf8()); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [7:0] s; logic co, ov; int lat;
        run8(8'h5A, 8'h3C, 1'b0, 1'b0, 0, s, co, ov, lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        total++; if (s !== 8'h96) begin bad++; $display("FAIL basic_sum got=%h exp=96", s); end
        total++; if (co !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b exp=0", co); end
        total++; if (bus8.in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_done got=%b exp=0", bus8.in_ready); end
        @(negedge clk);
        total++; if (bus8.out_valid !== 1'b0) begin bad++; $display("FAIL basic_done_one_cycle got=%b exp=0", bus8.out_valid); end
        total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready_back got=%b exp=1", bus8.in_ready); end
        total++; if (bus8.sum !== 8'h96) begin bad++; $display("FAIL basic_sum_hold got=%h exp=96", bus8.sum); end
    endtask

    task automatic test_carry;
        logic [7:0] s; logic co, ov; int lat;
        run8(8'hFF, 8'h01, 1'b0, 1'b0, 0, s, co, ov, lat);
        total++; if ({co, s} !== 9'h100) begin bad++; $display("FAIL carry_ff_01 got=%h exp=100", {co, s}); end
        run8(8'hFF, 8'hFF, 1'b1, 1'b0, 0, s, co, ov, lat);
        total++; if ({co, s} !== 9'h1FF) begin bad++; $display("FAIL carry_ff_ff_1 got=%h exp=1ff", {co, s}); end
    endtask

    task automatic test_backpressure;
        logic [7:0] s; logic co, ov; int lat; int n = 0;
        @(negedge clk);
        bus8.a = 8'h33; bus8.b = 8'h44; bus8.cin = 1'b0; set_sub8(1'b0);
        bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
        while (!bus8.in_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus8.in_valid = 1'b0;
        n = 0;
        while (!bus8.out_valid && n < 50) begin @(negedge clk); n++; end
        total++; if (n !== 8) begin bad++; $display("FAIL bp_latency got=%0d exp=8", n); end
        bus8.a = 8'h01; bus8.b = 8'h01; bus8.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (bus8.out_valid !== 1'b1 || bus8.sum !== 8'h77 || bus8.cout !== 1'b0 || bus8.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got v=%b s=%h c=%b r=%b exp v=1 s=77 c=0 r=0",
                         i, bus8.out_valid, bus8.sum, bus8.cout, bus8.in_ready);
            end
        end
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", bus8.in_ready); end
        run8(8'h01, 8'h01, 1'b0, 1'b0, 0, s, co, ov, lat);
        total++; if ({co, s} !== 9'h002) begin bad++; $display("FAIL bp_next_op got=%h exp=002", {co, s}); end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        @(negedge clk);
        bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0; set_sub8(1'b0);
        bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
        while (!bus8.in_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus8.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (bus8.sum !== 8'h00 || bus8.cout !== 1'b0 || bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got s=%h c=%b r=%b v=%b exp s=00 c=0 r=1 v=0",
                     bus8.sum, bus8.cout, bus8.in_ready, bus8.out_valid);
        end
        bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0; bus8.in_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        n = 0;
        while (!bus8.out_valid && n < 50) begin @(negedge clk); n++; end
        total++; if (n !== 8) begin bad++; $display("FAIL release_accept_latency got=%0d exp=8", n); end
        total++; if ({bus8.cout, bus8.sum} !== 9'h030) begin bad++; $display("FAIL post_reset_sum got=%h exp=030", {bus8.cout, bus8.sum}); end
    endtask

    task automatic test_random8;
        logic [7:0] s, ra, rb; logic co, ov, rc, rs; int lat; logic [9:0] e;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            e = model8(ra, rb, rc, rs);
            run8(ra, rb, rc, rs, int'($urandom_range(0, 3)), s, co, ov, lat);
            total++;
            if (lat !== 8 || {co, s} !== e[8:0]) begin
                bad++;
                $display("FAIL rand8 a=%h b=%h ci=%b sub=%b got lat=%0d r=%h exp lat=8 r=%h", ra, rb, rc, rs, lat, {co, s}, e[8:0]);
            end
`ifdef SERIAL_ADDER_SUB_EN
            total++; if (ov !== e[9]) begin bad++; $display("FAIL rand8_ovf a=%h b=%h sub=%b got=%b exp=%b", ra, rb, rs, ov, e[9]); end
`endif
        end
    endtask

    task automatic test_exhaustive4;
        int n, lat;
        logic [4:0] exp_r;
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++) begin
                    @(negedge clk);
                    bus4.a = 4'(ia); bus4.b = 4'(ib); bus4.cin = 1'(ic);
                    bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
                    n = 0;
                    while (!bus4.in_ready && n < 50) begin @(negedge clk); n++; end
                    @(negedge clk);
                    bus4.in_valid = 1'b0;
                    bus4.a = 4'($urandom); bus4.b = 4'($urandom); bus4.cin = 1'($urandom);
                    lat = 0;
                    while (!bus4.out_valid && lat < 50) begin @(negedge clk); lat++; end
                    repeat (int'($urandom_range(0, 3))) @(negedge clk);
                    exp_r = 5'(ia + ib + ic);
                    total++;
                    if (lat !== 4 || {bus4.cout, bus4.sum} !== exp_r) begin
                        bad++;
                        $display("FAIL exh4 a=%0d b=%0d ci=%0d got lat=%0d r=%h exp lat=4 r=%h", ia, ib, ic, lat, {bus4.cout, bus4.sum}, exp_r);
                    end
                    bus4.out_ready = 1'b1;
                    @(negedge clk);
                    bus4.out_ready = 1'b0;
                end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        logic [7:0] s; logic co, ov; int lat;
        run8(8'h05, 8'h07, 1'b0, 1'b1, 0, s, co, ov, lat);
        total++; if ({ov, co, s} !== 10'h0FE) begin bad++; $display("FAIL sub_5_7 got=%h exp=0fe", {ov, co, s}); end
        run8(8'h80, 8'h01, 1'b0, 1'b1, 0, s, co, ov, lat);
        total++; if ({ov, co, s} !== 10'h37F) begin bad++; $display("FAIL sub_80_1 got=%h exp=37f", {ov, co, s}); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_backpressure;
        test_reset_mid;
`ifdef SERIAL_ADDER_SUB_EN
        test_sub;
`endif
        test_random8;
        test_exhaustive4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
